// File: rtl/ycbcr_pkg.sv
// Shared constants for the multi-standard RGB to YCbCr converter:
// mode encoding, coefficient table (x256), offsets and pipeline depth.
package ycbcr_pkg;

  typedef enum logic [1:0] {
    MODE_709L = 2'd0,
    MODE_601L = 2'd1,
    MODE_601F = 2'd2,
    MODE_GRAY = 2'd3
  } mode_e;

  localparam int FRAC_BITS = 8;
  localparam int PIPE_LAT  = 4;

  localparam logic [7:0] Y_OFF = 8'd16;
  localparam logic [7:0] C_OFF = 8'd128;

  // [mode][channel Y/Cb/Cr][component R/G/B]
  localparam logic signed [8:0] COEF [4][3][3] = '{
    '{'{ 9'sd47,   9'sd157,  9'sd16 },
      '{-9'sd26,  -9'sd86,   9'sd112},
      '{ 9'sd112, -9'sd102, -9'sd10 }},
    '{'{ 9'sd66,   9'sd129,  9'sd25 },
      '{-9'sd38,  -9'sd74,   9'sd112},
      '{ 9'sd112, -9'sd94,  -9'sd18 }},
    '{'{ 9'sd77,   9'sd150,  9'sd29 },
      '{-9'sd43,  -9'sd85,   9'sd128},
      '{ 9'sd128, -9'sd107, -9'sd21 }},
    '{'{ 9'sd77,   9'sd150,  9'sd29 },
      '{ 9'sd0,    9'sd0,    9'sd0  },
      '{ 9'sd0,    9'sd0,    9'sd0  }}
  };

endpackage

// File: rtl/ycbcr_channel.sv
// One output channel: multiply, partial sums, final sum, round/saturate.
// Ports: r/g/b + per-pixel mode in, q (4 cycles later) + clip bit out.
module ycbcr_channel
  import ycbcr_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int CH     = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] r,
  input  logic [DATA_W-1:0] g,
  input  logic [DATA_W-1:0] b,
  input  logic [1:0]        mode,
  output logic [DATA_W-1:0] q,
  output logic              clip
);

  localparam int PW = DATA_W + 10;
  localparam int SW = DATA_W + 12;
  localparam logic signed [SW-1:0] RND =
    SW'(1 << (FRAC_BITS - 1));

  function automatic logic signed [PW-1:0] mul(
    input logic [DATA_W-1:0] x,
    input logic signed [8:0] k
  );
    logic signed [PW-1:0] xs;
    logic signed [PW-1:0] ks;
    xs = {10'd0, x};
    ks = {{(PW-9){k[8]}}, k};
    return xs * ks;
  endfunction

  logic [7:0]           base;
  logic signed [SW-1:0] off_c;
  logic signed [PW-1:0] p_r, p_g, p_b;
  logic signed [SW-1:0] off1, sa, sb, sum, shr;
  logic                 neg, over;

  // Offsets grow with the component width and sit on the x256 scale.
  assign base  = (CH != 0) ? C_OFF
               : (mode[1] ? 8'd0 : Y_OFF);
  assign off_c = {{(SW-8){1'b0}}, base}
                 << (DATA_W - 8 + FRAC_BITS);

  assign shr  = sum >>> FRAC_BITS;
  assign neg  = shr[SW-1];
  assign over = ~neg & (|shr[SW-2:DATA_W]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_r  <= '0;
      p_g  <= '0;
      p_b  <= '0;
      off1 <= '0;
      sa   <= '0;
      sb   <= '0;
      sum  <= '0;
      q    <= '0;
      clip <= 1'b0;
    end else begin
      p_r  <= mul(r, COEF[mode][CH][0]);
      p_g  <= mul(g, COEF[mode][CH][1]);
      p_b  <= mul(b, COEF[mode][CH][2]);
      off1 <= off_c;
      sa   <= SW'(p_r) + SW'(p_g);
      sb   <= SW'(p_b) + off1 + RND;
      sum  <= sa + sb;
      q    <= neg ? '0
            : (over ? '1 : shr[DATA_W-1:0]);
      clip <= neg | over;
    end
  end

endmodule

// File: rtl/rgb_to_ycbcr_mc.sv
// Multi-standard RGB to YCbCr, one pixel/clock, 4-cycle latency.
// Mode latched on input v_sync rise; o_clip sticky per output frame.
module rgb_to_ycbcr_mc
  import ycbcr_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] i_r,
  input  logic [DATA_W-1:0] i_g,
  input  logic [DATA_W-1:0] i_b,
  input  logic              i_h_sync,
  input  logic              i_v_sync,
  input  logic              i_data_en,
  input  logic [1:0]        i_mode,
  output logic [DATA_W-1:0] o_y,
  output logic [DATA_W-1:0] o_cb,
  output logic [DATA_W-1:0] o_cr,
  output logic              o_h_sync,
  output logic              o_v_sync,
  output logic              o_data_en,
  output logic [1:0]        o_mode,
  output logic              o_clip
);

  logic  v_prev, v_rise;
  mode_e act_mode, px_mode;

  logic [PIPE_LAT-1:0][4:0] dly;

  logic clip_y, clip_cb, clip_cr;
  logic ov_prev, ov_rise, sticky, clamp;

  // The pixel carrying the v_sync rise already uses the new mode.
  assign v_rise  = i_v_sync & ~v_prev;
  assign px_mode = v_rise ? mode_e'(i_mode) : act_mode;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_prev   <= 1'b0;
      act_mode <= MODE_709L;
      dly      <= '0;
      ov_prev  <= 1'b0;
      sticky   <= 1'b0;
    end else begin
      v_prev   <= i_v_sync;
      act_mode <= px_mode;
      dly      <= {dly[PIPE_LAT-2:0],
                   {px_mode, i_h_sync,
                    i_v_sync, i_data_en}};
      ov_prev  <= o_v_sync;
      sticky   <= o_clip;
    end
  end

  assign {o_mode, o_h_sync, o_v_sync, o_data_en} =
    dly[PIPE_LAT-1];

  ycbcr_channel #(.DATA_W(DATA_W), .CH(0)) u_y (
    .clk(clk), .rst_n(rst_n),
    .r(i_r), .g(i_g), .b(i_b), .mode(px_mode),
    .q(o_y), .clip(clip_y)
  );

  ycbcr_channel #(.DATA_W(DATA_W), .CH(1)) u_cb (
    .clk(clk), .rst_n(rst_n),
    .r(i_r), .g(i_g), .b(i_b), .mode(px_mode),
    .q(o_cb), .clip(clip_cb)
  );

  ycbcr_channel #(.DATA_W(DATA_W), .CH(2)) u_cr (
    .clk(clk), .rst_n(rst_n),
    .r(i_r), .g(i_g), .b(i_b), .mode(px_mode),
    .q(o_cr), .clip(clip_cr)
  );

  // A clamp on the frame's first output pixel survives the clear.
  assign clamp   = o_data_en & (clip_y | clip_cb | clip_cr);
  assign ov_rise = o_v_sync & ~ov_prev;
  assign o_clip  = clamp | (sticky & ~ov_rise);

endmodule

// File: tb/tb_rgb_to_ycbcr_mc.sv
// Scoreboard bench for rgb_to_ycbcr_mc at DATA_W=8 and DATA_W=10.
// Driver pushes model results; monitor pops on o_data_en.
module tb_rgb_to_ycbcr_mc;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] r8 = '0, g8 = '0, b8 = '0;
  logic [9:0] r10 = '0, g10 = '0, b10 = '0;
  logic hs = 1'b0, vs = 1'b0, de = 1'b0;
  logic [1:0] md = '0;

  logic [7:0] y8, cb8, cr8;
  logic [9:0] y10, cb10, cr10;
  logic oh8, ov8, ode8, oc8;
  logic oh10, ov10, ode10, oc10;
  logic [1:0] om8, om10;

  rgb_to_ycbcr_mc #(.DATA_W(8)) u8 (
    .clk(clk), .rst_n(rst_n),
    .i_r(r8), .i_g(g8), .i_b(b8),
    .i_h_sync(hs), .i_v_sync(vs), .i_data_en(de),
    .i_mode(md),
    .o_y(y8), .o_cb(cb8), .o_cr(cr8),
    .o_h_sync(oh8), .o_v_sync(ov8), .o_data_en(ode8),
    .o_mode(om8), .o_clip(oc8)
  );

  rgb_to_ycbcr_mc #(.DATA_W(10)) u10 (
    .clk(clk), .rst_n(rst_n),
    .i_r(r10), .i_g(g10), .i_b(b10),
    .i_h_sync(hs), .i_v_sync(vs), .i_data_en(de),
    .i_mode(md),
    .o_y(y10), .o_cb(cb10), .o_cr(cr10),
    .o_h_sync(oh10), .o_v_sync(ov10), .o_data_en(ode10),
    .o_mode(om10), .o_clip(oc10)
  );

  typedef struct {
    int y8, cb8, cr8;
    int y10, cb10, cr10;
    int h, v, mode, c8, c10, cyc;
  } exp_t;

  exp_t q[$];
  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  int  m_mode = 0;
  bit  m_vprev = 1'b0;
  bit  fc8 = 1'b0, fc10 = 1'b0;

  int K [4][3][3] = '{
    '{'{47, 157, 16}, '{-26, -86, 112}, '{112, -102, -10}},
    '{'{66, 129, 25}, '{-38, -74, 112}, '{112, -94, -18}},
    '{'{77, 150, 29}, '{-43, -85, 128}, '{128, -107, -21}},
    '{'{77, 150, 29}, '{0, 0, 0}, '{0, 0, 0}}
  };

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string nm, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Plain fixed-point formula: sum(k*c) + offset*2^(w-8)*256, rounded.
  function automatic int conv(int w, int m, int ch,
                              int r, int g, int b,
                              output bit cl);
    int acc, off, mx;
    off = (ch == 0) ? ((m < 2) ? 16 : 0) : 128;
    acc = K[m][ch][0] * r + K[m][ch][1] * g
        + K[m][ch][2] * b
        + off * (1 << (w - 8)) * 256 + 128;
    acc = acc >>> 8;
    mx = (1 << w) - 1;
    cl = (acc < 0) || (acc > mx);
    return (acc < 0) ? 0 : ((acc > mx) ? mx : acc);
  endfunction

  task automatic px(int ra, int ga, int ba,
                    int ra10, int ga10, int ba10,
                    bit h, bit v, bit d, int im,
                    int gy = -1, int gcb = -1, int gcr = -1,
                    int ty = -1, int tcb = -1, int tcr = -1);
    exp_t e;
    bit c, l8, l10;
    @(negedge clk);
    r8 = 8'(ra); g8 = 8'(ga); b8 = 8'(ba);
    r10 = 10'(ra10); g10 = 10'(ga10); b10 = 10'(ba10);
    hs = h; vs = v; de = d; md = 2'(im);
    if (v && !m_vprev) begin
      m_mode = im;
      fc8 = 1'b0;
      fc10 = 1'b0;
    end
    m_vprev = v;
    e.y8  = conv(8, m_mode, 0, ra, ga, ba, c); l8 = c;
    e.cb8 = conv(8, m_mode, 1, ra, ga, ba, c); l8 |= c;
    e.cr8 = conv(8, m_mode, 2, ra, ga, ba, c); l8 |= c;
    e.y10  = conv(10, m_mode, 0, ra10, ga10, ba10, c); l10 = c;
    e.cb10 = conv(10, m_mode, 1, ra10, ga10, ba10, c); l10 |= c;
    e.cr10 = conv(10, m_mode, 2, ra10, ga10, ba10, c); l10 |= c;
    if (gy >= 0) begin
      e.y8 = gy; e.cb8 = gcb; e.cr8 = gcr;
    end
    if (ty >= 0) begin
      e.y10 = ty; e.cb10 = tcb; e.cr10 = tcr;
    end
    if (d) begin
      fc8 |= l8;
      fc10 |= l10;
    end
    e.h = int'(h); e.v = int'(v); e.mode = m_mode;
    e.c8 = int'(fc8); e.c10 = int'(fc10); e.cyc = cyc;
    if (d) q.push_back(e);
  endtask

  function automatic int rc(int w);
    int mx;
    mx = (1 << w) - 1;
    case ($urandom_range(0, 3))
      0: return 0;
      1: return mx;
      default: return int'($urandom_range(0, mx));
    endcase
  endfunction

  task automatic rnd_px(bit h, bit v, bit d);
    px(rc(8), rc(8), rc(8), rc(10), rc(10), rc(10),
       h, v, d, int'($urandom_range(0, 3)));
  endtask

  task automatic frame(int lines, int npx);
    rnd_px(1'b0, 1'b1, 1'b0);
    rnd_px(1'b0, 1'b1, 1'b0);
    for (int l = 0; l < lines; l++) begin
      for (int p = 0; p < npx; p++)
        rnd_px(1'b0, 1'b0, 1'b1);
      rnd_px(1'b1, 1'b0, 1'b0);
      rnd_px(1'b1, 1'b0, 1'b0);
    end
  endtask

  task automatic chk_zero(string tag);
    chk({tag, "_y8"}, int'(y8), 0);
    chk({tag, "_cb8"}, int'(cb8), 0);
    chk({tag, "_cr8"}, int'(cr8), 0);
    chk({tag, "_de8"}, int'(ode8), 0);
    chk({tag, "_h8"}, int'(oh8), 0);
    chk({tag, "_v8"}, int'(ov8), 0);
    chk({tag, "_mode8"}, int'(om8), 0);
    chk({tag, "_clip8"}, int'(oc8), 0);
    chk({tag, "_cb10"}, int'(cb10), 0);
    chk({tag, "_mode10"}, int'(om10), 0);
  endtask

  // Monitor: every o_data_en pixel must match the head of the queue.
  initial begin
    exp_t em;
    forever begin
      @(posedge clk);
      #1;
      if (rst_n && ode8) begin
        if (q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL stale_px: got data_en=1 expected none");
        end else begin
          em = q.pop_front();
          chk("latency", cyc - em.cyc, 4);
          chk("y8", int'(y8), em.y8);
          chk("cb8", int'(cb8), em.cb8);
          chk("cr8", int'(cr8), em.cr8);
          chk("h8", int'(oh8), em.h);
          chk("v8", int'(ov8), em.v);
          chk("mode8", int'(om8), em.mode);
          chk("clip8", int'(oc8), em.c8);
          chk("de10", int'(ode10), 1);
          chk("y10", int'(y10), em.y10);
          chk("cb10", int'(cb10), em.cb10);
          chk("cr10", int'(cr10), em.cr10);
          chk("mode10", int'(om10), em.mode);
          chk("clip10", int'(oc10), em.c10);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected done");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    chk_zero("rst_init");
    rst_n = 1'b1;

    // mode 0 basics
    px(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    px(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    px(255, 255, 255, 1023, 1023, 1023, 0, 0, 1, 0,
       235, 128, 128, 943, 512, 512);
    px(0, 0, 0, 0, 0, 0, 1, 0, 1, 0,
       16, 128, 128, 64, 512, 512);
    px(0, 0, 255, 0, 0, 1023, 0, 0, 1, 0,
       32, 240, 118);
    // mid-frame request for gray is ignored
    px(255, 0, 0, 1023, 0, 0, 0, 0, 1, 3,
       63, 102, 240);
    // gray takes effect on the v_sync rise pixel itself
    px(255, 0, 0, 1023, 0, 0, 0, 1, 1, 3,
       77, 128, 128);
    px(0, 0, 0, 0, 0, 0, 0, 1, 0, 3);
    px(0, 0, 0, 0, 0, 0, 0, 0, 0, 2);
    // full-range BT.601, clamp and sticky clip
    px(0, 0, 0, 0, 0, 0, 0, 1, 0, 2);
    px(0, 0, 0, 0, 0, 0, 0, 0, 0, 2);
    px(255, 0, 0, 1023, 0, 0, 0, 0, 1, 2,
       77, 85, 255);
    px(0, 0, 0, 0, 0, 0, 0, 0, 1, 1,
       0, 128, 128);
    px(0, 0, 0, 0, 0, 0, 0, 0, 0, 2);
    // v rise on an active pixel clears clip
    px(0, 0, 0, 0, 0, 0, 0, 1, 1, 2,
       0, 128, 128);
    px(0, 0, 0, 0, 0, 0, 0, 0, 1, 2);
    px(0, 0, 0, 0, 0, 0, 0, 0, 0, 2);
    // clamp on the clearing pixel still reports
    px(255, 0, 0, 1023, 0, 0, 0, 1, 1, 2,
       77, 85, 255);
    px(0, 0, 0, 0, 0, 0, 0, 0, 1, 2);
    px(0, 0, 0, 0, 0, 0, 0, 0, 0, 2);

    for (int f = 0; f < 4; f++) frame(3, 10);

    // reset with pixels in flight
    for (int i = 0; i < 6; i++) rnd_px(1'b0, 1'b0, 1'b1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_zero("rst_mid");
    q.delete();
    m_mode = 0;
    m_vprev = 1'b0;
    fc8 = 1'b0;
    fc10 = 1'b0;
    hs = 1'b0; vs = 1'b0; de = 1'b0; md = 2'd2;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    // mode stays 0 until the next v_sync rise
    px(255, 0, 0, 1023, 0, 0, 0, 0, 1, 2,
       63, 102, 240);
    for (int i = 0; i < 5; i++) rnd_px(1'b0, 1'b0, 1'b1);
    for (int f = 0; f < 3; f++) frame(3, 8);
    px(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < 20 && q.size() > 0; i++)
      @(negedge clk);
    chk("drain", q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
